// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock divider with run-time reloadable divisors applied at period wrap.
// Optional macro CLKDIV_TICK_EN enables the registered per-channel rise-tick output.
module multi_clock_divider #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned CNT_W       = 26,
    parameter int unsigned DEFAULT_DIV = 50000,
    localparam int unsigned SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk50MHz,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] enable,
    input  logic                div_load,
    input  logic [SEL_W-1:0]    div_sel,
    input  logic [CNT_W-1:0]    div_value,
    output logic                load_ack,
    output logic                load_err,
    output logic [CHANNELS-1:0] div_applied,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick
);

    localparam logic [CNT_W-1:0] DefDiv  = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] DefCnt  = CNT_W'(DEFAULT_DIV - 1);
    localparam logic [SEL_W:0]   ChanLim = (SEL_W + 1)'(CHANNELS);

    logic [CNT_W-1:0]    cnt_q    [CHANNELS];
    logic [CNT_W-1:0]    cnt_d    [CHANNELS];
    logic [CNT_W-1:0]    div_q    [CHANNELS];
    logic [CNT_W-1:0]    div_d    [CHANNELS];
    logic [CNT_W-1:0]    pend_q   [CHANNELS];
    logic [CNT_W-1:0]    pend_d   [CHANNELS];
    logic [CHANNELS-1:0] pend_v_q, pend_v_d;
    logic [CHANNELS-1:0] clk_out_q, clk_out_d;
    logic [CHANNELS-1:0] applied_q, applied_d;
    logic [CHANNELS-1:0] wrap, apply;
    logic                load_ack_q, load_ack_d;
    logic                load_err_q, load_err_d;
    logic                sel_ok, load_ok;

    always_comb begin
        sel_ok     = ({1'b0, div_sel} < ChanLim);
        load_ok    = div_load & sel_ok & (div_value >= CNT_W'(2));
        load_ack_d = load_ok;
        load_err_d = div_load & ~load_ok;
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            wrap[i]  = (cnt_q[i] == div_q[i] - CNT_W'(1));
            // A disabled channel has no period to finish, so it takes the new divisor at once.
            apply[i] = pend_v_q[i] & (wrap[i] | ~enable[i]);

            div_d[i]     = apply[i] ? pend_q[i] : div_q[i];
            applied_d[i] = apply[i];
            pend_d[i]    = pend_q[i];
            pend_v_d[i]  = pend_v_q[i] & ~apply[i];
            // A load landing on the apply cycle re-arms pending with the newer value.
            if (load_ok && (div_sel == SEL_W'(i))) begin
                pend_d[i]   = div_value;
                pend_v_d[i] = 1'b1;
            end

            if (enable[i]) begin
                cnt_d[i]     = wrap[i] ? '0 : cnt_q[i] + CNT_W'(1);
                clk_out_d[i] = (cnt_d[i] < (div_d[i] >> 1));
            end else begin
                // Park at the last count so the first enabled cycle wraps and rises.
                cnt_d[i]     = div_d[i] - CNT_W'(1);
                clk_out_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk50MHz or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]  <= DefCnt;
                div_q[i]  <= DefDiv;
                pend_q[i] <= DefDiv;
            end
            pend_v_q   <= '0;
            clk_out_q  <= '0;
            applied_q  <= '0;
            load_ack_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]  <= cnt_d[i];
                div_q[i]  <= div_d[i];
                pend_q[i] <= pend_d[i];
            end
            pend_v_q   <= pend_v_d;
            clk_out_q  <= clk_out_d;
            applied_q  <= applied_d;
            load_ack_q <= load_ack_d;
            load_err_q <= load_err_d;
        end
    end

    assign clk_out     = clk_out_q;
    assign div_applied = applied_q;
    assign load_ack    = load_ack_q;
    assign load_err    = load_err_q;

`ifdef CLKDIV_TICK_EN
    logic [CHANNELS-1:0] tick_q, tick_d;

    always_comb begin
        tick_d = clk_out_d & ~clk_out_q;
    end

    always_ff @(posedge clk50MHz or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
`else
    assign tick = '0;
`endif

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed bench for multi_clock_divider: per-cycle vector table plus hand-written corner sequences.
module tb_multi_clock_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  en;
    logic        ld;
    logic [1:0]  sel;
    logic [25:0] val;
    logic        ack, err;
    logic [3:0]  app, clko, tck;

    logic [2:0]  d3_en;
    logic        d3_ld;
    logic [1:0]  d3_sel;
    logic [7:0]  d3_val;
    logic        d3_ack, d3_err;
    logic [2:0]  d3_app, d3_clko, d3_tck;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    multi_clock_divider #(.CHANNELS(4), .CNT_W(26), .DEFAULT_DIV(10)) dut (
        .clk50MHz(clk), .rst_n(rst_n), .enable(en), .div_load(ld), .div_sel(sel),
        .div_value(val), .load_ack(ack), .load_err(err), .div_applied(app),
        .clk_out(clko), .tick(tck)
    );

    multi_clock_divider #(.CHANNELS(3), .CNT_W(8), .DEFAULT_DIV(4)) dut3 (
        .clk50MHz(clk), .rst_n(rst_n), .enable(d3_en), .div_load(d3_ld), .div_sel(d3_sel),
        .div_value(d3_val), .load_ack(d3_ack), .load_err(d3_err), .div_applied(d3_app),
        .clk_out(d3_clko), .tick(d3_tck)
    );

    typedef struct {
        logic [3:0]  en;
        logic        ld;
        logic [1:0]  sel;
        logic [25:0] val;
        logic [3:0]  clk;
        logic        ack;
        logic        err;
        logic [3:0]  app;
        logic [3:0]  tck;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(input logic ld_i, input logic [1:0] sel_i, input logic [25:0] val_i,
                                input logic [3:0] clk_i, input logic ack_i, input logic err_i,
                                input logic [3:0] app_i, input logic [3:0] tck_i);
        vec_t v;
        v.en  = 4'b0010;
        v.ld  = ld_i;
        v.sel = sel_i;
        v.val = val_i;
        v.clk = clk_i;
        v.ack = ack_i;
        v.err = err_i;
        v.app = app_i;
        v.tck = tck_i;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] exp_tick(input logic [3:0] t);
`ifdef CLKDIV_TICK_EN
        return t;
`else
        return 4'b0000 & t;
`endif
    endfunction

    // Called just after clk_out[ch] rose; returns high/low run lengths of that period.
    task automatic run_lengths(input int ch, output int hi, output int lo, output logic app_seen);
        hi = 1;
        lo = 0;
        app_seen = 1'b0;
        step();
        while (clko[ch] && hi < 200) begin
            hi++;
            app_seen |= app[ch];
            step();
        end
        while (!clko[ch] && lo < 200) begin
            lo++;
            app_seen |= app[ch];
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int hi, lo;
        logic app_seen;
        logic [2:0] d3_exp_clk [5];
        logic [2:0] d3_exp_tck [5];

        // Channel 1 runs at default 10; load 5 to ch1, bad loads, then load 6 to disabled ch2.
        tbl[0]  = mk(0, 0, 0, 4'b0010, 0, 0, 4'b0000, 4'b0010);
        tbl[1]  = mk(0, 0, 0, 4'b0010, 0, 0, 4'b0000, 4'b0000);
        tbl[2]  = mk(1, 1, 5, 4'b0010, 1, 0, 4'b0000, 4'b0000);
        tbl[3]  = mk(0, 0, 0, 4'b0010, 0, 0, 4'b0000, 4'b0000);
        tbl[4]  = mk(1, 1, 1, 4'b0010, 0, 1, 4'b0000, 4'b0000);
        tbl[5]  = mk(0, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        tbl[6]  = mk(1, 0, 0, 4'b0000, 0, 1, 4'b0000, 4'b0000);
        tbl[7]  = mk(1, 2, 6, 4'b0000, 1, 0, 4'b0000, 4'b0000);
        tbl[8]  = mk(0, 0, 0, 4'b0000, 0, 0, 4'b0100, 4'b0000);
        tbl[9]  = mk(0, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        tbl[10] = mk(0, 0, 0, 4'b0010, 0, 0, 4'b0010, 4'b0010);
        tbl[11] = mk(0, 0, 0, 4'b0010, 0, 0, 4'b0000, 4'b0000);
        tbl[12] = mk(0, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        tbl[13] = mk(0, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        tbl[14] = mk(0, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        tbl[15] = mk(0, 0, 0, 4'b0010, 0, 0, 4'b0000, 4'b0010);
        tbl[16] = mk(0, 0, 0, 4'b0010, 0, 0, 4'b0000, 4'b0000);

        d3_exp_clk = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b001};
        d3_exp_tck = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b001};

        rst_n = 1'b0;
        en = '0; ld = 1'b0; sel = '0; val = '0;
        d3_en = '0; d3_ld = 1'b0; d3_sel = '0; d3_val = '0;
        #2;
        check("reset clk_out", 32'(clko), 0);
        check("reset ack/err", 32'({ack, err}), 0);
        check("reset applied", 32'(app), 0);
        check("reset tick", 32'(tck), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 17; i++) begin
            en  = tbl[i].en;
            ld  = tbl[i].ld;
            sel = tbl[i].sel;
            val = tbl[i].val;
            step();
            check($sformatf("row%0d clk_out", i), 32'(clko), 32'(tbl[i].clk));
            check($sformatf("row%0d load_ack", i), 32'(ack), 32'(tbl[i].ack));
            check($sformatf("row%0d load_err", i), 32'(err), 32'(tbl[i].err));
            check($sformatf("row%0d applied", i), 32'(app), 32'(tbl[i].app));
            check($sformatf("row%0d tick", i), 32'(tck), 32'(exp_tick(tbl[i].tck)));
        end
        ld = 1'b0;

        // Channel 2 (div 6): enable, drop while high, re-enable for a full high phase.
        en = 4'b0110;
        step();
        check("ch2 first rise", 32'(clko[2]), 1);
        step();
        check("ch2 still high", 32'(clko[2]), 1);
        en = 4'b0010;
        step();
        check("ch2 low after disable", 32'(clko[2]), 0);
        en = 4'b0110;
        step();
        check("ch2 rise after re-enable", 32'(clko[2]), 1);
        run_lengths(2, hi, lo, app_seen);
        check("ch2 high run", 32'(hi), 3);
        check("ch2 low run", 32'(lo), 3);

        // Reset mid-run with a pending load on channel 1.
        en = 4'b0010;
        ld = 1'b1; sel = 2'd1; val = 26'd7;
        step();
        ld = 1'b0;
        check("pending load ack", 32'(ack), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset clk_out", 32'(clko), 0);
        check("async reset ack", 32'(ack), 0);
        check("async reset applied", 32'(app), 0);
        check("async reset tick", 32'(tck), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post-reset rise", 32'(clko[1]), 1);
        run_lengths(1, hi, lo, app_seen);
        check("post-reset high run", 32'(hi), 5);
        check("post-reset low run", 32'(lo), 5);
        check("post-reset no applied", 32'(app_seen), 0);

        // Three-channel instance: out-of-range select, then a valid load and a div-4 run.
        d3_ld = 1'b1; d3_sel = 2'd3; d3_val = 8'd5;
        step();
        check("d3 bad sel err", 32'(d3_err), 1);
        check("d3 bad sel ack", 32'(d3_ack), 0);
        d3_sel = 2'd2;
        step();
        check("d3 good sel ack", 32'(d3_ack), 1);
        check("d3 good sel err", 32'(d3_err), 0);
        d3_ld = 1'b0;
        step();
        check("d3 applied ch2", 32'(d3_app), 32'(3'b100));
        d3_en = 3'b001;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("d3 div4 clk_out %0d", k), 32'(d3_clko), 32'(d3_exp_clk[k]));
`ifdef CLKDIV_TICK_EN
            check($sformatf("d3 div4 tick %0d", k), 32'(d3_tck), 32'(d3_exp_tck[k]));
`else
            check($sformatf("d3 div4 tick %0d", k), 32'(d3_tck), 0);
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
